// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM scheduler and the pwm_gen output stage:
// configuration address map, scheduler states and functions bit positions.
package pwm_pkg;

    localparam logic [2:0] ADDR_PERIOD = 3'd0;
    localparam logic [2:0] ADDR_CMP1   = 3'd1;
    localparam logic [2:0] ADDR_CMP2   = 3'd2;
    localparam logic [2:0] ADDR_FUNC   = 3'd3;
    localparam logic [2:0] ADDR_PSC    = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_e;

    // Bit positions inside the 8-bit functions word, decoded by pwm_gen.
    localparam int FN_CMP1_EN  = 0;
    localparam int FN_CMP2_EN  = 1;
    localparam int FN_INV_OUT  = 2;
    localparam int FN_CENTER   = 3;
    localparam int FN_ONE_SHOT = 4;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus wrap counter. count_val runs 0..period inclusive; boundary
// pulses on the tick where the counter wraps back to 0.
module pwm_timebase #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [PSC_W-1:0] prescale,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] count_val,
    output logic             boundary
);

    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        tick      = run && (psc_cnt_q == prescale);
        boundary  = tick && (cnt_q == period);
        psc_cnt_d = '0;
        cnt_d     = '0;
        // Both counters collapse to 0 while idle so a restart begins a clean period.
        if (run) begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_W'(1);
            if (tick) begin
                cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign count_val = cnt_q;

endmodule

// File: rtl/pwm_sched.sv
// Timebase and configuration controller for pwm_gen: staged/active config with
// glitch-free commit at the period wrap. Optional PWM_SCHED_OVF_IRQ_EN adds a sticky wrap IRQ.
module pwm_sched
    import pwm_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter int               PSC_W      = 8,
    parameter logic [CNT_W-1:0] RST_PERIOD = 16'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             cfg_commit,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    output logic             pwm_en,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       functions,
    output logic [CNT_W-1:0] compare1,
    output logic [CNT_W-1:0] compare2,
    output logic [CNT_W-1:0] count_val,
    output logic             upd_pending,
    output logic             upd_done,
    output logic             busy
`ifdef PWM_SCHED_OVF_IRQ_EN
    ,
    input  logic             irq_clr,
    output logic             ovf_irq
`endif
);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] stg_period_q, stg_period_d;
    logic [CNT_W-1:0] stg_cmp1_q, stg_cmp1_d;
    logic [CNT_W-1:0] stg_cmp2_q, stg_cmp2_d;
    logic [7:0]       stg_func_q, stg_func_d;
    logic [PSC_W-1:0] stg_psc_q, stg_psc_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_cmp1_q, act_cmp1_d;
    logic [CNT_W-1:0] act_cmp2_q, act_cmp2_d;
    logic [7:0]       act_func_q, act_func_d;
    logic [PSC_W-1:0] act_psc_q, act_psc_d;
    logic             run;
    logic             boundary;
    logic             apply;

    assign run = (state_q != S_IDLE);

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PSC_W (PSC_W)
    ) u_timebase (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .prescale  (act_psc_q),
        .period    (act_period_q),
        .count_val (count_val),
        .boundary  (boundary)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (cmd_start && !cmd_stop) state_d = S_RUN;
            S_RUN:      if (cmd_stop) state_d = S_STOPPING;
            S_STOPPING: begin
                if (cmd_start && !cmd_stop) state_d = S_RUN;
                else if (boundary)          state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // A commit re-arms even on the cycle it applies, so a commit landing on a
    // boundary waits for the following one.
    always_comb begin
        apply     = pending_q && (!run || boundary);
        pending_d = cfg_commit ? 1'b1 : (apply ? 1'b0 : pending_q);
        done_d    = apply;

        stg_period_d = stg_period_q;
        stg_cmp1_d   = stg_cmp1_q;
        stg_cmp2_d   = stg_cmp2_q;
        stg_func_d   = stg_func_q;
        stg_psc_d    = stg_psc_q;
        if (cfg_wr) begin
            case (cfg_addr)
                ADDR_PERIOD: stg_period_d = cfg_wdata;
                ADDR_CMP1:   stg_cmp1_d   = cfg_wdata;
                ADDR_CMP2:   stg_cmp2_d   = cfg_wdata;
                ADDR_FUNC:   stg_func_d   = cfg_wdata[7:0];
                ADDR_PSC:    stg_psc_d    = cfg_wdata[PSC_W-1:0];
                default:     ;
            endcase
        end

        act_period_d = act_period_q;
        act_cmp1_d   = act_cmp1_q;
        act_cmp2_d   = act_cmp2_q;
        act_func_d   = act_func_q;
        act_psc_d    = act_psc_q;
        if (apply) begin
            act_period_d = stg_period_q;
            act_cmp1_d   = stg_cmp1_q;
            act_cmp2_d   = stg_cmp2_q;
            act_func_d   = stg_func_q;
            act_psc_d    = stg_psc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            stg_period_q <= RST_PERIOD;
            stg_cmp1_q   <= '0;
            stg_cmp2_q   <= '0;
            stg_func_q   <= '0;
            stg_psc_q    <= '0;
            act_period_q <= RST_PERIOD;
            act_cmp1_q   <= '0;
            act_cmp2_q   <= '0;
            act_func_q   <= '0;
            act_psc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            stg_period_q <= stg_period_d;
            stg_cmp1_q   <= stg_cmp1_d;
            stg_cmp2_q   <= stg_cmp2_d;
            stg_func_q   <= stg_func_d;
            stg_psc_q    <= stg_psc_d;
            act_period_q <= act_period_d;
            act_cmp1_q   <= act_cmp1_d;
            act_cmp2_q   <= act_cmp2_d;
            act_func_q   <= act_func_d;
            act_psc_q    <= act_psc_d;
        end
    end

`ifdef PWM_SCHED_OVF_IRQ_EN
    logic ovf_irq_q, ovf_irq_d;

    always_comb begin
        ovf_irq_d = ovf_irq_q;
        if (boundary)     ovf_irq_d = 1'b1;
        else if (irq_clr) ovf_irq_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_irq_q <= 1'b0;
        else        ovf_irq_q <= ovf_irq_d;
    end

    assign ovf_irq = ovf_irq_q;
`endif

    assign pwm_en      = run;
    assign busy        = run;
    assign period      = act_period_q;
    assign functions   = act_func_q;
    assign compare1    = act_cmp1_q;
    assign compare2    = act_cmp2_q;
    assign upd_pending = pending_q;
    assign upd_done    = done_q;

endmodule

// File: doc/pwm_sched.md
Name: pwm_sched

Overview:
- Timebase and configuration controller for the pwm_gen output stage.
- Owns the count_val counter with prescaler. Holds the staged and active copies of period, compare1, compare2 and functions. Sequences start and stop.
- New configuration is committed glitch-free: it is applied only at a period boundary, the counter wrap point.
- Sits between the register/bus front-end (cfg_* inputs) and one pwm_gen instance.

Parameters:
- CNT_W, 16, width of counter, period, compare1, compare2.
- PSC_W, 8, prescaler register width.
- RST_PERIOD, 16'd8, reset value of staged and active period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  staging-register write strobe
- cfg_addr  in  3  0=period, 1=compare1, 2=compare2, 3=functions (low 8 bits), 4=prescale (low PSC_W bits); 5-7 ignored
- cfg_wdata  in  CNT_W  write data
- cfg_commit  in  1  request transfer of staging to active at next boundary
- cmd_start  in  1  start pulse
- cmd_stop  in  1  stop pulse; takes effect at end of current period
- pwm_en  out  1  enable to pwm_gen
- period  out  CNT_W  active period
- functions  out  8  active functions
- compare1  out  CNT_W  active compare1
- compare2  out  CNT_W  active compare2
- count_val  out  CNT_W  counter value
- upd_pending  out  1  commit accepted, not yet applied
- upd_done  out  1  one-cycle pulse when active registers load
- busy  out  1  state != IDLE

Behaviour:
- Reset values (asynchronous, active-low):
  - All outputs 0, except period = RST_PERIOD.
  - Staged registers: period = RST_PERIOD, others 0.
  - Prescale = 0 and prescaler count = 0.
  - State = IDLE.
- States:
  - IDLE: count_val held 0, pwm_en=0, prescaler held 0.
  - RUN: pwm_en=1, counter advances.
  - STOPPING: as RUN, but returns to IDLE at the next boundary.
- Transitions:
  - IDLE -> RUN on cmd_start. The first tick comes PSC+1 clocks later, and count_val=0 is visible from the cycle after cmd_start.
  - RUN -> STOPPING on cmd_stop.
  - STOPPING -> IDLE on the cycle the counter wraps: count_val=0, pwm_en=0.
  - cmd_start while STOPPING -> RUN, and the stop is cancelled.
  - cmd_start while RUN is ignored. cmd_stop while IDLE is ignored.
  - cmd_start and cmd_stop together: cmd_stop wins.
- Prescaler: tick when prescaler count == prescale, then the count resets to 0. prescale=0 gives a tick every clock.
- Counter: on a tick, count_val increments. When count_val == period it wraps to 0 instead, and that wrap is the boundary. Sequence is 0..period inclusive, i.e. period+1 ticks per cycle.
- period=0: count_val stays 0 and every tick is a boundary.
- Period lowered below current count: wrap applies only to the active period, which updates at the boundary, so the wrap stays well-defined.
- Staging writes: written the cycle after cfg_wr. They never affect the active outputs directly.
- Commit:
  - cfg_commit sets upd_pending.
  - At the next boundary (RUN/STOPPING), or on the next clock if IDLE, active <= staging, upd_pending clears and upd_done pulses.
  - The prescale register is applied at the same point.
  - Commit while already pending keeps pending, and the latest staging contents are applied.
- Same-cycle events:
  - cfg_wr and cfg_commit together: the write is included in the commit.
  - cfg_commit on the boundary cycle itself: applies at the following boundary.
- Reset mid-operation: immediate return to reset values, and any pending commit is lost.

Optional Feature:
- Macro PWM_SCHED_OVF_IRQ_EN.
- When defined:
  - Adds input irq_clr (1) and output ovf_irq (1).
  - ovf_irq sets on every boundary while RUN/STOPPING and is sticky.
  - irq_clr clears it; on a same-cycle set and clear, set wins. Reset value 0.
- When undefined: ports absent, no logic.

Decomposition:
- Package pwm_pkg holds:
  - the cfg_addr constants (ADDR_PERIOD, ADDR_CMP1, ADDR_CMP2, ADDR_FUNC, ADDR_PSC);
  - the state enum (S_IDLE, S_RUN, S_STOPPING);
  - the functions bit positions shared with pwm_gen.
- One natural sub-module, pwm_timebase: prescaler plus wrap counter.
  - Inputs: run, prescale, period.
  - Outputs: count_val, boundary pulse.

Test Plan:
- Reset, write period=8, cmp1=3, cmp2=6, functions=0x02, commit in IDLE -> upd_done one cycle later, outputs show 8/3/6/0x02.
- cmd_start with prescale=0 -> count_val 0,1..8,0 on consecutive clocks and pwm_en=1. With prescale=2, each value is held 3 clocks.
- While RUN at count 4, write cmp1=5 and commit -> compare1 stays 3 until count_val wraps 8->0, then becomes 5. upd_pending is high between.
- cmd_stop at count 2 -> counter continues to 8, wraps to 0, pwm_en falls the same cycle, busy=0.
- period=0 with RUN -> count_val constant 0 and a commit applies on the next tick. cmd_start and cmd_stop in the same cycle from RUN -> STOPPING.
- Assert rst_n low mid-period with commit pending -> all outputs return to reset values immediately. With PWM_SCHED_OVF_IRQ_EN, ovf_irq sets at the wrap and clears on irq_clr.
